map9v3_collect: RTL and testbench
=================================

MAP9V3_COLLECT -- requirements
Module: map9v3_collect

Interface
REQ-001 Parameter DP_W, default 9: width of captured result word.
REQ-002 Parameter DEPTH, default 8: result buffer entries (power of two).
REQ-003 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port done_in  input  1  completion flag from the upstream map9v3 stage; level signal, may stay high many cycles.
REQ-006 Port dp_in  input  DP_W  upstream result word; valid in the cycle done_in rises.
REQ-007 Port flush  input  1  synchronous clear of buffer, count and overflow.
REQ-008 Port out_data  output  DP_W  head-of-buffer word; valid only while out_valid=1.
REQ-009 Port out_valid  output  1  buffer non-empty.
REQ-010 Port out_ready  input  1  consumer accepts head this cycle.
REQ-011 Port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 Port full  output  1  level==DEPTH.
REQ-013 Port count  output  8  results accepted since reset/flush.
REQ-014 Port overflow  output  1  sticky; a result was dropped.

Function
REQ-015 Block SHALL register done_in into done_q and define capture = done_in & ~done_q (rising edge only; a held-high done_in yields one capture).
REQ-016 On capture, dp_in SHALL be sampled in that same cycle; a done_in high in the first cycle after reset release SHALL count as a rising edge.
REQ-017 Push = capture & (~full | pop); pop = out_valid & out_ready.
REQ-018 Captured word SHALL appear on out_data with out_valid=1 one cycle after capture if buffer was empty (latency 1).
REQ-019 out_data SHALL be first-word-fall-through: head entry driven combinationally from storage, no extra read cycle.
REQ-020 Buffer order SHALL be strict FIFO.
REQ-021 Simultaneous push and pop SHALL leave level unchanged, including when full (slot freed by pop is reused).
REQ-022 Pop when empty SHALL be impossible (out_valid=0); out_ready is ignored then.
REQ-023 Capture while full and no pop SHALL drop dp_in, leave buffer and count unchanged, and set overflow=1.
REQ-024 overflow SHALL remain 1 until flush or reset.
REQ-025 count SHALL increment by 1 per accepted push, wrapping 255->0.
REQ-026 Read/write pointers SHALL be $clog2(DEPTH)+1 bits with wrap bit; empty when equal, full when only MSB differs.
REQ-027 flush SHALL take priority over push and pop in its cycle: next cycle level=0, out_valid=0, count=0, overflow=0; a capture in the flush cycle is discarded.
REQ-028 done_q SHALL keep tracking done_in during flush, so a done_in held across flush is not re-captured.

Reset
REQ-029 reset low SHALL immediately force: pointers=0, level=0, out_valid=0, full=0, count=0, overflow=0, done_q=0.
REQ-030 out_data SHALL be 0 during reset (storage array cleared or output masked).
REQ-031 Reset asserted mid-operation SHALL discard all buffered results; no partial pop/push completes.

Structure
REQ-032 Shared package map9v3_pkg SHALL hold DP_W, DEPTH, and the count width constant, shared with map9v3 and its benches.
REQ-033 Storage and pointers SHALL be one sub-module map9v3_fifo (push, pop, flush, data in/out, level, full, empty); edge detect, count and overflow stay in map9v3_collect.

Verification
REQ-034 Reset release, done_in 0->1 with dp_in=9'h0DC, held high 10 cycles, out_ready=0 -> exactly one entry, out_data=9'h0DC, level=1, count=1.
REQ-035 Nine done_in pulses with dp_in=1..9, out_ready=0 -> level=8, full=1, overflow=1, count=8; draining yields 1..8 in order.
REQ-036 Full buffer, capture with out_ready=1 same cycle -> level stays 8, overflow=0, head advances, new word at tail.
REQ-037 Empty buffer, capture of 9'h1FF with out_ready=1 held -> out_valid high exactly one cycle, 9'h1FF delivered once, level back to 0.
REQ-038 Three entries buffered, overflow=1, flush asserted together with a capture -> next cycle level=0, count=0, overflow=0, out_valid=0.
REQ-039 reset driven low asynchronously between clock edges with level=5 -> outputs reach reset values before the next edge; 256 accepted captures afterwards -> count wraps to 0.

Source files
------------

// File: rtl/map9v3_pkg.sv
// Shared constants for the map9v3 stage, its result collector and benches.
package map9v3_pkg;
  localparam int unsigned DP_W  = 9;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 8;
endpackage

// File: rtl/map9v3_fifo.sv
// First-word-fall-through result buffer with wrap-bit pointers and synchronous flush.
module map9v3_fifo
  import map9v3_pkg::*;
#(
  parameter int unsigned W = DP_W,
  parameter int unsigned D = DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic                 i_flush,
  input  logic [W-1:0]         i_wdata,
  output logic [W-1:0]         o_rdata,
  output logic [$clog2(D):0]   o_level,
  output logic                 o_full,
  output logic                 o_empty
);
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Flush wins over both ports; pop is masked when empty.
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level = r_wptr - r_rptr;
  // Head masked to zero when empty, which also covers the reset state.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
endmodule

// File: rtl/map9v3_collect.sv
// Collects map9v3 results on done_in rising edges into a FIFO, with count and sticky overflow.
module map9v3_collect
  import map9v3_pkg::*;
#(
  parameter int unsigned DP_W  = map9v3_pkg::DP_W,
  parameter int unsigned DEPTH = map9v3_pkg::DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     done_in,
  input  logic [DP_W-1:0]          dp_in,
  input  logic                     flush,
  output logic [DP_W-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow
);
  logic             r_done_q;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_capture;
  logic             w_pop;
  logic             w_push;
  logic             w_empty;

  assign w_capture = done_in & ~r_done_q;
  assign w_pop     = ~w_empty & out_ready;
  assign w_push    = w_capture & (~full | w_pop);
  assign out_valid = ~w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

  // Edge detector keeps tracking through flush so a held level is not re-captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_done_q <= 1'b0;
    else        r_done_q <= done_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_count <= r_count + CNT_W'(1);
      if (w_capture & full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  map9v3_fifo #(
    .W (DP_W),
    .D (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (dp_in),
    .o_rdata (out_data),
    .o_level (level),
    .o_full  (full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_map9v3_collect.sv
// Self-checking bench for map9v3_collect against a queue-based reference model.
module tb_map9v3_collect;
  localparam int unsigned DP_W  = 9;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            done_in = 1'b0;
  logic [DP_W-1:0] dp_in = '0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic [DP_W-1:0] out_data;
  logic            out_valid;
  logic [LW-1:0]   level;
  logic            full;
  logic [7:0]      count;
  logic            overflow;

  int errors = 0;
  int checks = 0;

  logic [DP_W-1:0] m_q[$];
  int              m_count = 0;
  bit              m_ovf = 1'b0;
  bit              m_prev = 1'b0;

  map9v3_collect #(.DP_W(DP_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .done_in(done_in), .dp_in(dp_in), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance the reference model, and step past the edge.
  task automatic cyc(input bit d, input logic [DP_W-1:0] dp, input bit fl, input bit rdy);
    bit cap, pop, was_full;
    done_in = d; dp_in = dp; flush = fl; out_ready = rdy;
    cap = d && !m_prev;
    pop = (m_q.size() > 0) && rdy;
    was_full = (m_q.size() == DEPTH);
    if (fl) begin
      m_q.delete(); m_count = 0; m_ovf = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        if (!was_full || pop) begin
          m_q.push_back(dp);
          m_count = (m_count + 1) % 256;
        end else m_ovf = 1'b1;
      end
    end
    m_prev = d;
    @(posedge clock); #1;
  endtask

  task automatic model_reset();
    m_q.delete(); m_count = 0; m_ovf = 1'b0; m_prev = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_hold_high();
    cyc(1'b1, 9'h0DC, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, DP_W'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 9'h000, 1'b0, 1'b0);
    checks++; if (level !== LW'(1)) begin errors++; $display("FAIL hold_level got=%0d want=1", level); end
    checks++; if (out_data !== 9'h0DC) begin errors++; $display("FAIL hold_data got=%h want=0dc", out_data); end
    checks++; if (count !== 8'd1) begin errors++; $display("FAIL hold_count got=%0d want=1", count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b want=1", out_valid); end
  endtask

  task automatic test_overflow_order();
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, DP_W'(i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
    end
    checks++; if (level !== LW'(8)) begin errors++; $display("FAIL ovf_level got=%0d want=8", level); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b want=1", full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    checks++; if (count !== 8'd8) begin errors++; $display("FAIL ovf_count got=%0d want=8", count); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== DP_W'(i)) begin
        errors++; $display("FAIL drain_%0d got=%h valid=%b want=%h", i, out_data, out_valid, DP_W'(i));
      end
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b want=0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_full_pop_push();
    logic [DP_W-1:0] nw;
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, DP_W'($urandom), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
    end
    nw = DP_W'($urandom);
    cyc(1'b1, nw, 1'b0, 1'b1);
    checks++; if (level !== LW'(8)) begin errors++; $display("FAIL fullpp_level got=%0d want=8", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%b want=0", overflow); end
    checks++; if (m_q[DEPTH-1] !== nw) begin errors++; $display("FAIL fullpp_model_tail got=%h want=%h", m_q[DEPTH-1], nw); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_data !== m_q[0]) begin errors++; $display("FAIL fullpp_drain_%0d got=%h want=%h", i, out_data, m_q[0]); end
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_fwft();
    int vcycles = 0;
    bit seen = 1'b0;
    cyc(1'b1, 9'h1FF, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (out_valid === 1'b1) begin
        vcycles++;
        if (out_data === 9'h1FF) seen = 1'b1;
      end
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    checks++; if (vcycles != 1) begin errors++; $display("FAIL fwft_valid_cycles got=%0d want=1", vcycles); end
    checks++; if (!seen) begin errors++; $display("FAIL fwft_data got=missing want=1ff"); end
    checks++; if (level !== '0) begin errors++; $display("FAIL fwft_level got=%0d want=0", level); end
  endtask

  task automatic test_flush_capture();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, DP_W'($urandom), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    checks++; if (level !== LW'(3) || overflow !== 1'b1) begin
      errors++; $display("FAIL flush_setup got=%0d/%b want=3/1", level, overflow);
    end
    cyc(1'b1, 9'h0AA, 1'b1, 1'b0);
    checks++; if (level !== '0) begin errors++; $display("FAIL flush_level got=%0d want=0", level); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b want=0", overflow); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    cyc(1'b1, 9'h0BB, 1'b0, 1'b0);
    checks++; if (level !== '0) begin errors++; $display("FAIL flush_nocap got=%0d want=0", level); end
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset_wrap();
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, DP_W'($urandom), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
    end
    checks++; if (level !== LW'(5)) begin errors++; $display("FAIL arst_setup got=%0d want=5", level); end
    #2 reset = 1'b0;
    #1;
    checks++; if (level !== '0 || out_valid !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL arst_fifo got=%0d/%b/%b want=0/0/0", level, out_valid, full);
    end
    checks++; if (count !== 8'd0 || overflow !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL arst_regs got=%0d/%b/%h want=0/0/0", count, overflow, out_data);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, DP_W'($urandom), 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      if (i == 254) begin
        checks++; if (count !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d want=255", count); end
      end
    end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL wrap_0 got=%0d want=0", count); end
  endtask

  task automatic test_random();
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 2) != 0 ? ~m_prev : m_prev), DP_W'($urandom),
          bit'($urandom_range(0, 49) == 0), bit'($urandom_range(0, 2) == 0));
      checks++;
      if (level !== LW'(m_q.size()) || full !== (m_q.size() == DEPTH) || out_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL rnd_occ cyc=%0d got=%0d/%b/%b want=%0d", i, level, full, out_valid, m_q.size());
      end
      checks++;
      if (count !== 8'(m_count) || overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%b want=%0d/%b", i, count, overflow, m_count, m_ovf);
      end
      if (m_q.size() > 0) begin
        checks++;
        if (out_data !== m_q[0]) begin errors++; $display("FAIL rnd_head cyc=%0d got=%h want=%h", i, out_data, m_q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_high();
    test_overflow_order();
    test_full_pop_push();
    test_fwft();
    test_flush_capture();
    test_async_reset_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
